// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix size, FSM encoding
// and the layout of the 5-bit key event code.
package keypad_scanner_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

  localparam int EVT_W         = 5;
  localparam int EVT_PRESS_BIT = 4;
  localparam int EVT_COL_LSB   = 2;
  localparam int EVT_ROW_LSB   = 0;

  localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SCAN   = 1'b1
  } scan_state_t;

  function automatic logic [EVT_W-1:0] make_evt(input logic       press,
                                                input logic [1:0] col,
                                                input logic [1:0] row);
    logic [EVT_W-1:0] code;
    code                     = '0;
    code[EVT_PRESS_BIT]      = press;
    code[EVT_COL_LSB +: 2]   = col;
    code[EVT_ROW_LSB +: 2]   = row;
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_fifo.sv
// First-word fall-through event FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same clock.
module kbd_evt_fifo
  import keypad_scanner_pkg::*;
#(
  parameter int p_AW    = 2,
  parameter int p_WIDTH = EVT_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [p_WIDTH-1:0] iv_push_data,
  input  logic               i_pop,
  output logic [p_WIDTH-1:0] ov_pop_data,
  output logic               o_full,
  output logic               o_empty
);

  localparam int DEPTH = 1 << p_AW;
  localparam logic [p_AW-1:0] PTR_ONE = p_AW'(1);
  localparam logic [p_AW:0]   CNT_ONE = (p_AW + 1)'(1);

  logic [p_WIDTH-1:0] mem [DEPTH];
  logic [p_AW-1:0]    wr_ptr;
  logic [p_AW-1:0]    rd_ptr;
  logic [p_AW:0]      count;
  logic               do_push;
  logic               do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign o_full      = count[p_AW];
  assign o_empty     = (count == '0);
  assign do_pop      = i_pop & ~o_empty;
  assign do_push     = i_push & (~o_full | do_pop);
  assign ov_pop_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= iv_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, debounces every key with a
// shared counter datapath and queues press/release events in a small FIFO.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int p_SETTLE_WIDTH = 4,
  parameter int p_DEB_WIDTH    = 2,
  parameter int p_FIFO_AW      = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic [NUM_COLS-1:0] ov_col,
  input  logic [NUM_ROWS-1:0] iv_row,
  output logic [NUM_KEYS-1:0] ov_keys,
  output logic                o_evt_valid,
  input  logic                i_evt_ready,
  output logic [EVT_W-1:0]    ov_evt_code,
  output logic                o_overflow,
  input  logic                i_ovf_clr
);

  localparam logic [p_SETTLE_WIDTH-1:0] SETTLE_LAST = '1;
  localparam logic [p_SETTLE_WIDTH-1:0] SETTLE_ONE  = p_SETTLE_WIDTH'(1);
  localparam logic [p_DEB_WIDTH-1:0]    DEB_LAST    = '1;
  localparam logic [p_DEB_WIDTH-1:0]    DEB_ONE     = p_DEB_WIDTH'(1);

  scan_state_t               state;
  scan_state_t               state_next;
  logic [p_SETTLE_WIDTH-1:0] settle_cnt;
  logic [p_SETTLE_WIDTH-1:0] settle_next;
  logic [1:0]                col_idx;
  logic [1:0]                col_next;
  logic [1:0]                row_idx;
  logic [1:0]                row_next;
  logic [NUM_ROWS-1:0]       row_latch;
  logic                      latch_en;
  logic                      scan_en;

  logic [p_DEB_WIDTH-1:0]    deb_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0]       keys;
  logic [3:0]                key_idx;
  logic                      raw_pressed;
  logic                      key_differs;
  logic                      deb_expired;
  logic [p_DEB_WIDTH-1:0]    cnt_cur;
  logic [p_DEB_WIDTH-1:0]    cnt_upd;

  logic                      evt_push;
  logic [EVT_W-1:0]          evt_code;
  logic                      evt_pop;
  logic                      evt_drop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      overflow;

  // The column drive follows col_idx, which only moves on SCAN -> SETTLE
  assign ov_col = ~(NUM_COLS'(1) << col_idx);

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    row_next    = row_idx;
    col_next    = col_idx;
    latch_en    = 1'b0;
    scan_en     = 1'b0;
    unique case (state)
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          latch_en    = 1'b1;
          settle_next = '0;
          row_next    = '0;
          state_next  = ST_SCAN;
        end else begin
          settle_next = settle_cnt + SETTLE_ONE;
        end
      end
      ST_SCAN: begin
        scan_en  = 1'b1;
        row_next = row_idx + 2'd1;
        if (row_idx == LAST_ROW) begin
          col_next   = col_idx + 2'd1;
          state_next = ST_SETTLE;
        end
      end
      default: state_next = ST_SETTLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
      row_latch  <= '1;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      col_idx    <= col_next;
      row_idx    <= row_next;
      if (latch_en) begin
        row_latch <= iv_row;
      end
    end
  end

  // One key per SCAN clock shares this compare/increment path
  always_comb begin
    key_idx     = {col_idx, row_idx};
    raw_pressed = ~row_latch[row_idx];
    cnt_cur     = deb_cnt[key_idx];
    key_differs = (raw_pressed != keys[key_idx]);
    deb_expired = key_differs && (cnt_cur == DEB_LAST);
    cnt_upd     = '0;
    if (key_differs && !deb_expired) begin
      cnt_upd = cnt_cur + DEB_ONE;
    end
    evt_push = scan_en && deb_expired;
    evt_code = make_evt(raw_pressed, col_idx, row_idx);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        deb_cnt[k] <= '0;
      end
      keys <= '0;
    end else if (scan_en) begin
      deb_cnt[key_idx] <= cnt_upd;
      if (deb_expired) begin
        keys[key_idx] <= raw_pressed;
      end
    end
  end

  assign evt_pop  = o_evt_valid & i_evt_ready;
  assign evt_drop = evt_push & fifo_full & ~evt_pop;

  // A drop wins over a clear arriving in the same clock
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overflow <= 1'b0;
    end else if (evt_drop) begin
      overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  kbd_evt_fifo #(
    .p_AW    (p_FIFO_AW),
    .p_WIDTH (EVT_W)
  ) u_evt_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (evt_push),
    .iv_push_data (evt_code),
    .i_pop        (evt_pop),
    .ov_pop_data  (ov_evt_code),
    .o_full       (fifo_full),
    .o_empty      (fifo_empty)
  );

  assign o_evt_valid = ~fifo_empty;
  assign ov_keys     = keys;
  assign o_overflow  = overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a behavioural keypad drives the rows,
// expected events are queued as keys change and a monitor checks each pop.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_code;
  logic        overflow;
  logic        ovf_clr;

  logic [15:0] pressed;
  logic [4:0]  exp_q[$];
  logic [4:0]  exp_code;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  keypad_scanner dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .ov_col      (col),
    .iv_row      (row),
    .ov_keys     (keys),
    .o_evt_valid (evt_valid),
    .i_evt_ready (evt_ready),
    .ov_evt_code (evt_code),
    .o_overflow  (overflow),
    .i_ovf_clr   (ovf_clr)
  );

  // Pressed keys in the driven (low) column pull their row low
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[4*c+r]) row[r] = 1'b0;
        end
      end
    end
  end

  function automatic logic [4:0] evt(input logic p, input int c, input int r);
    return {p, 2'(c), 2'(r)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_event: got 0x%0h, expected no event", evt_code);
      end else begin
        exp_code = exp_q.pop_front();
        check_output("event_code", {27'd0, evt_code}, {27'd0, exp_code});
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns just after the edge that starts column 0 settling
  task automatic sync_scan_start();
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = col;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (prev == 4'b0111 && col == 4'b1110) found = 1'b1;
      prev = col;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scan_sync: got no column wrap, expected one within 200 clocks");
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] exp_col;
    rst_n     = 1'b0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    pressed   = '0;
    wait_cycles(3);
    check_output("reset_col", col, 4'b1110);
    check_output("reset_keys", keys, 16'h0000);
    check_output("reset_valid", evt_valid, 1'b0);
    check_output("reset_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    // Idle column walk, 20 clocks per column
    sync_scan_start();
    for (int c = 0; c < 4; c++) begin
      exp_col = ~(4'b0001 << c);
      check_output($sformatf("col_walk_first_%0d", c), col, exp_col);
      wait_cycles(19);
      check_output($sformatf("col_walk_last_%0d", c), col, exp_col);
      wait_cycles(1);
    end
    check_output("idle_keys", keys, 16'h0000);
    check_output("idle_valid", evt_valid, 1'b0);

    // Press and release col2,row1
    sync_scan_start();
    pressed[9] = 1'b1;
    exp_q.push_back(evt(1'b1, 2, 1));
    wait_cycles(240);
    check_output("press_after_3_scans", keys, 16'h0000);
    wait_cycles(80);
    check_output("press_after_4_scans", keys, 16'h0200);
    wait_cycles(80);
    pressed[9] = 1'b0;
    exp_q.push_back(evt(1'b0, 2, 1));
    wait_cycles(240);
    check_output("release_after_3_scans", keys, 16'h0200);
    wait_cycles(80);
    check_output("release_after_4_scans", keys, 16'h0000);

    // Two 3-scan glitches split by one agreeing scan must not accumulate
    sync_scan_start();
    pressed[6] = 1'b1;
    wait_cycles(240);
    pressed[6] = 1'b0;
    wait_cycles(80);
    pressed[6] = 1'b1;
    wait_cycles(240);
    check_output("glitch_mid", keys, 16'h0000);
    pressed[6] = 1'b0;
    wait_cycles(160);
    check_output("glitch_end", keys, 16'h0000);

    // Five presses with the consumer stalled: fifth event is dropped
    evt_ready = 1'b0;
    sync_scan_start();
    pressed = pressed | 16'h8429;
    exp_q.push_back(evt(1'b1, 0, 0));
    exp_q.push_back(evt(1'b1, 0, 3));
    exp_q.push_back(evt(1'b1, 1, 1));
    exp_q.push_back(evt(1'b1, 2, 2));
    wait_cycles(330);
    check_output("overflow_set", overflow, 1'b1);
    check_output("overflow_keys", keys, 16'h8429);
    check_output("overflow_valid", evt_valid, 1'b1);
    check_output("head_code", evt_code, evt(1'b1, 0, 0));
    wait_cycles(5);
    check_output("head_code_hold", evt_code, evt(1'b1, 0, 0));

    ovf_clr = 1'b1;
    wait_cycles(1);
    ovf_clr = 1'b0;
    check_output("overflow_cleared", overflow, 1'b0);

    // Release col0,row0 and pop exactly on the clock its event is pushed
    sync_scan_start();
    pressed[0] = 1'b0;
    exp_q.push_back(evt(1'b0, 0, 0));
    wait_cycles(256);
    evt_ready = 1'b1;
    wait_cycles(1);
    evt_ready = 1'b0;
    check_output("full_push_with_pop_ovf", overflow, 1'b0);
    check_output("full_push_with_pop_keys", keys, 16'h8428);
    check_output("full_push_with_pop_valid", evt_valid, 1'b1);
    evt_ready = 1'b1;
    wait_cycles(10);
    check_output("fifo_drained", evt_valid, 1'b0);

    sync_scan_start();
    pressed = '0;
    exp_q.push_back(evt(1'b0, 0, 3));
    exp_q.push_back(evt(1'b0, 1, 1));
    exp_q.push_back(evt(1'b0, 2, 2));
    exp_q.push_back(evt(1'b0, 3, 3));
    wait_cycles(400);
    check_output("all_released", keys, 16'h0000);

    // Reset mid-scan with queued events discards them
    evt_ready = 1'b0;
    sync_scan_start();
    pressed[4]  = 1'b1;
    pressed[11] = 1'b1;
    wait_cycles(400);
    check_output("queued_before_reset", evt_valid, 1'b1);
    sync_scan_start();
    wait_cycles(17);
    rst_n = 1'b0;
    wait_cycles(1);
    check_output("midscan_reset_valid", evt_valid, 1'b0);
    check_output("midscan_reset_keys", keys, 16'h0000);
    check_output("midscan_reset_col", col, 4'b1110);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    exp_q.push_back(evt(1'b1, 1, 0));
    exp_q.push_back(evt(1'b1, 2, 3));
    wait_cycles(400);
    check_output("held_across_reset", keys, 16'h0810);
    pressed = '0;
    exp_q.push_back(evt(1'b0, 1, 0));
    exp_q.push_back(evt(1'b0, 2, 3));
    wait_cycles(400);
    check_output("final_keys", keys, 16'h0000);
    check_output("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter p_SETTLE_WIDTH, default 4, column settle time of 2^p_SETTLE_WIDTH clocks.
REQ-002 SHALL have parameter p_DEB_WIDTH, default 2, per-key debounce counter width; a change is accepted after 2^p_DEB_WIDTH consecutive disagreeing scans.
REQ-003 SHALL have parameter p_FIFO_AW, default 2, event FIFO address width, depth 2^p_FIFO_AW.
REQ-004 i_clk  in  1  sole clock; all logic on posedge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 ov_col  out  4  column drive, active-low one-hot; one column low at a time.
REQ-007 iv_row  in  4  row sense, active-low (pressed = 0), already synchronised externally.
REQ-008 ov_keys  out  16  debounced key state, bit 4*col+row, 1 = pressed.
REQ-009 o_evt_valid  out  1  FIFO head event valid.
REQ-010 i_evt_ready  in  1  consumer accepts head event when high together with o_evt_valid.
REQ-011 ov_evt_code  out  5  {press=1/release=0, col[1:0], row[1:0]}.
REQ-012 o_overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-013 i_ovf_clr  in  1  clears o_overflow for one cycle pulse.

Function
REQ-014 FSM states SETTLE, SCAN; SETTLE drives current column and counts 2^p_SETTLE_WIDTH clocks.
REQ-015 On the last SETTLE clock, iv_row SHALL be latched and FSM enters SCAN with row index 0.
REQ-016 SCAN processes one key per clock, rows 0..3, 4 clocks; after row 3, column index increments (3 wraps to 0) and FSM returns to SETTLE.
REQ-017 ov_col SHALL stay constant across SETTLE and SCAN of a column; it changes only on the SCAN->SETTLE transition.
REQ-018 Full scan period SHALL be 4*(2^p_SETTLE_WIDTH+4) clocks (80 at defaults).
REQ-019 Per key: latched raw equal to stable state -> counter cleared; else counter increments.
REQ-020 When counter is all-ones and raw still differs, stable bit SHALL toggle, counter clear, and one event be pushed in the same clock.
REQ-021 Counter SHALL saturate-free wrap only via the clear of REQ-020; it never wraps silently.
REQ-022 Events from keys in one column SHALL be pushed in row order, at most one per clock.
REQ-023 FIFO: first-word fall-through; o_evt_valid = not empty; pop when o_evt_valid & i_evt_ready.
REQ-024 Push when full without concurrent pop SHALL drop the event, set o_overflow; ov_keys still updates.
REQ-025 Push when full with concurrent pop SHALL be accepted; occupancy unchanged.
REQ-026 Push and pop on empty FIFO: event stored, o_evt_valid rises next clock.
REQ-027 i_ovf_clr and a new drop in the same clock: o_overflow SHALL remain 1.
REQ-028 ov_evt_code SHALL hold stable while o_evt_valid & !i_evt_ready.

Reset
REQ-029 While i_rst_n=0 at posedge: FSM=SETTLE, column 0, settle counter 0, ov_col=4'b1110.
REQ-030 Reset SHALL clear all per-key counters, ov_keys=0, FIFO empty (o_evt_valid=0), o_overflow=0.
REQ-031 Reset mid-scan or with FIFO occupied SHALL discard pending events; no event emitted for keys held across reset until accepted per REQ-020.

Structure
REQ-032 Shared package SHALL hold FSM state encoding, event-code field positions, 4x4 matrix dimensions.
REQ-033 FIFO SHALL be sub-module kbd_evt_fifo (width 5, depth 2^p_FIFO_AW, full/empty, FWFT).
REQ-034 Per-key counters SHALL be one 16-entry register array indexed by {col,row}; single shared increment/compare datapath.

Verification
REQ-035 Reset, no keys -> ov_col walks 1110,1101,1011,0111 every 20 clocks, no events, ov_keys=0.
REQ-036 Hold key col2,row1 pressed 5 scans -> after 4th disagreeing scan ov_keys[9]=1, one event 5'b1_10_01; release -> event 5'b0_10_01.
REQ-037 Glitch: key low for 3 scans then high -> no event, ov_keys unchanged, counter cleared.
REQ-038 i_evt_ready=0, press 5 distinct keys -> 4 events queued, 5th dropped, o_overflow=1; ov_keys shows all 5.
REQ-039 FIFO full, i_evt_ready=1 on clock of new push -> push accepted, no overflow; i_ovf_clr clears prior flag.
REQ-040 Assert i_rst_n=0 during SCAN with 2 events queued -> next clock o_evt_valid=0, ov_keys=0, ov_col=1110.
